// File: rtl/div_seq_ctrl.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU): one shared 32-bit CLA adder sequenced through
// operand preparation, 32 restoring iterations and a sign fix-up step.

module cla_adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);

  logic [31:0] g;
  logic [31:0] p;
  logic [32:0] c;
  logic        cin;
  logic        gg;
  logic        gp;

  // 4-bit lookahead groups; group carries chain between groups
  always_comb begin
    g   = a & b;
    p   = a ^ b;
    c   = '0;
    cin = 1'b0;
    gg  = 1'b0;
    gp  = 1'b0;
    c[0] = ci;
    for (int k = 0; k < 8; k++) begin
      cin = c[4*k];
      c[4*k+1] = g[4*k] | (p[4*k] & cin);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | ((&p[4*k +: 2]) & cin);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | ((&p[4*k+1 +: 2]) & g[4*k]) |
                 ((&p[4*k +: 3]) & cin);
      gg = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | ((&p[4*k+2 +: 2]) & g[4*k+1]) |
           ((&p[4*k+1 +: 3]) & g[4*k]);
      gp = &p[4*k +: 4];
      c[4*k+4] = gg | (gp & cin);
    end
    s  = p ^ c[31:0];
    co = c[32];
  end

endmodule

module div_seq_ctrl #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ITER_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [2:0] {StIdle, StPrep, StIter, StFix, StDone} state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [XLEN-1:0]   opa_q, opa_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   dvd_q, dvd_d;
  logic [XLEN-1:0]   div_q, div_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [ITER_W-1:0] cnt_q, cnt_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [XLEN-1:0]   add_a, add_b, add_s;
  logic              add_ci, add_co;

  logic              signed_op, b_zero, ovf, qbit, fix_neg, msb;
  logic [XLEN-1:0]   abs_b, rem_sh, fix_sel;

  cla_adder32 u_adder (
    .a  (add_a),
    .b  (add_b),
    .ci (add_ci),
    .s  (add_s),
    .co (add_co)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    dvd_d    = dvd_q;
    div_d    = div_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    // Idle adder inputs are held constant to avoid toggling
    add_a    = '0;
    add_b    = '1;
    add_ci   = 1'b0;
    qbit     = 1'b0;

    signed_op = ~op_q[0];
    b_zero    = (opb_q == '0);
    ovf       = signed_op && (opa_q == {1'b1, {(XLEN-1){1'b0}}}) && (opb_q == '1);
    // |b| uses its own incrementer so the shared adder is free for |a| in the same cycle
    abs_b     = (signed_op && opb_q[XLEN-1]) ? (~opb_q + 1'b1) : opb_q;
    rem_sh    = {rem_q[XLEN-2:0], dvd_q[XLEN-1]};
    msb       = rem_q[XLEN-1];
    fix_sel   = op_q[1] ? rem_q : dvd_q;
    fix_neg   = signed_op && (op_q[1] ? negr_q : negq_q);

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StPrep;
          op_d    = op;
          opa_d   = a;
          opb_d   = b;
        end else begin
          state_d = StIdle;
        end
      end
      StPrep: begin
        if (b_zero) begin
          result_d = op_q[1] ? opa_q : '1;
          state_d  = StDone;
        end else if (ovf) begin
          result_d = op_q[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
          state_d  = StDone;
        end else begin
          if (signed_op && opa_q[XLEN-1]) begin
            add_b  = ~opa_q;
            add_ci = 1'b1;
            dvd_d  = add_s;
          end else begin
            dvd_d = opa_q;
          end
          div_d   = abs_b;
          negq_d  = signed_op && (opa_q[XLEN-1] ^ opb_q[XLEN-1]);
          negr_d  = signed_op && opa_q[XLEN-1];
          rem_d   = '0;
          cnt_d   = ITER_W'(XLEN - 1);
          state_d = StIter;
        end
      end
      StIter: begin
        // 33-bit trial subtract: the shifted-out msb means the remainder already exceeds div
        add_a  = rem_sh;
        add_b  = ~div_q;
        add_ci = 1'b1;
        qbit   = msb | add_co;
        rem_d  = qbit ? add_s : rem_sh;
        dvd_d  = {dvd_q[XLEN-2:0], qbit};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = StFix;
        end
      end
      StFix: begin
        if (fix_neg) begin
          add_b    = ~fix_sel;
          add_ci   = 1'b1;
          result_d = add_s;
        end else begin
          result_d = fix_sel;
        end
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase

    if (flush && (state_q != StIdle)) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      dvd_q    <= '0;
      div_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      dvd_q    <= dvd_d;
      div_q    <= div_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == StPrep) || (state_q == StIter) || (state_q == StFix);
  assign done   = (state_q == StDone);
  assign result = result_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: latency, results, special cases, flush, reset and back-to-back.

module tb_div_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;
  int nbusy;
  logic seen_done;

  localparam logic [1:0] OpDiv  = 2'b00;
  localparam logic [1:0] OpDivu = 2'b01;
  localparam logic [1:0] OpRem  = 2'b10;
  localparam logic [1:0] OpRemu = 2'b11;

  div_seq_ctrl #(.XLEN(32), .ITER_W(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One-cycle start pulse; inputs are scrambled while busy to show they are latched.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp, input int exp_lat,
                       input int exp_busy);
    int l = 1;
    int nb = 0;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = x ^ 32'hA5A5_A5A5; b = ~y; op = ~o;
    while (!done && l < 100) begin
      if (busy) nb++;
      @(negedge clk);
      l++;
    end
    check({tag, "_lat"}, 32'(l), 32'(exp_lat));
    check({tag, "_busy"}, 32'(nb), 32'(exp_busy));
    check({tag, "_res"}, result, exp);
    check({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    rst_n = 1'b1;

    do_op("divu_100_7", OpDivu, 32'd100, 32'd7, 32'd14, 35, 34);
    do_op("remu_100_7", OpRemu, 32'd100, 32'd7, 32'd2, 35, 34);
    do_op("div_m7_2", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35, 34);
    do_op("rem_m7_2", OpRem, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35, 34);
    do_op("div_7_m2", OpDiv, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 35, 34);

    // Flush mid-iteration: result keeps 0xFFFFFFFD, no done
    @(negedge clk);
    start = 1'b1; op = OpDivu; a = 32'hFFFF_FFFF; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("flush_busy_before", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_done", {31'b0, done}, 32'd0);
    check("flush_result", result, 32'hFFFF_FFFD);
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen_done = seen_done | done | busy;
    end
    check("flush_quiet", {31'b0, seen_done}, 32'd0);
    do_op("remu_10_3", OpRemu, 32'd10, 32'd3, 32'd1, 35, 34);

    do_op("divu_by0", OpDivu, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 2, 1);
    do_op("remu_by0", OpRemu, 32'h1234_5678, 32'd0, 32'h1234_5678, 2, 1);
    do_op("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, 1);
    do_op("rem_ovf", OpRem, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2, 1);

    // Back-to-back: start held so DONE resamples it with new operands
    @(negedge clk);
    start = 1'b1; op = OpDivu; a = 32'd9; b = 32'd3;
    @(negedge clk);
    a = 32'd8; b = 32'd2;
    lat = 1;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    check("b2b_lat1", 32'(lat), 32'd35);
    check("b2b_res1", result, 32'd3);
    @(negedge clk);
    check("b2b_busy2", {31'b0, busy}, 32'd1);
    lat = 1;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    start = 1'b0;
    check("b2b_lat2", 32'(lat), 32'd35);
    check("b2b_res2", result, 32'd4);
    @(negedge clk);
    check("b2b_idle", {31'b0, busy | done}, 32'd0);

    // Flush and start together in DONE: flush wins
    start = 1'b1; op = OpDivu; a = 32'd20; b = 32'd4;
    lat = 0;
    @(negedge clk);
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    check("fs_res", result, 32'd5);
    flush = 1'b1;
    @(negedge clk);
    check("fs_busy", {31'b0, busy | done}, 32'd0);
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("fs_idle", {31'b0, busy | done}, 32'd0);

    // Reset mid-iteration
    @(negedge clk);
    start = 1'b1; op = OpDivu; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("rstmid_busy_before", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid_busy", {31'b0, busy}, 32'd0);
    check("rstmid_done", {31'b0, done}, 32'd0);
    check("rstmid_result", result, 32'd0);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen_done = seen_done | done;
    end
    check("rstmid_no_done", {31'b0, seen_done}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
